// File: rtl/a_buf_pkg.sv
// a_buf_pkg: shared definitions for the systolic A-operand staging buffer.
//   - TLOAD_DATAW_WIDTH and the one-hot element-width bit positions
//   - per-buffer state encoding
//   - width helpers used when unpacking a write beat into lanes
package a_buf_pkg;

  localparam int TLOAD_DATAW_WIDTH  = 3;
  localparam int TLOAD_DW_BYTE_IDX  = 0;
  localparam int TLOAD_DW_2BYTE_IDX = 1;
  localparam int TLOAD_DW_4BYTE_IDX = 2;

  typedef logic [TLOAD_DATAW_WIDTH-1:0] dw_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_FILL  = 2'd1,
    BUF_FULL  = 2'd2,
    BUF_DRAIN = 2'd3
  } buf_state_e;

  // Any width that is not exactly one-hot is handled as 4BYTE.
  function automatic dw_t norm_width(input dw_t w);
    dw_t res;
    case (w)
      3'b001, 3'b010, 3'b100: res = w;
      default: begin
        res = 3'b000;
        res[TLOAD_DW_4BYTE_IDX] = 1'b1;
      end
    endcase
    return res;
  endfunction

  // Element width in bits for a width tag.
  function automatic int unsigned width_bits(input dw_t w);
    int unsigned res;
    case (w)
      3'b001:  res = 32'd8;
      3'b010:  res = 32'd16;
      default: res = 32'd32;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/a_buf_pp_chk.sv
// a_buf_pp_chk: simulation checks for a_buf_pp.
//   clk, rst_n  clock, async active-low reset
//   wr_valid    write beat valid
//   wr_ready    write beat ready
//   wr_width    element width of the beat
module a_buf_pp_chk
  import a_buf_pkg::*;
(
  input logic clk,
  input logic rst_n,
  input logic wr_valid,
  input logic wr_ready,
  input dw_t  wr_width
);

  a_wr_width_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) (wr_valid && wr_ready) |-> $onehot(wr_width)
  );

endmodule

// File: rtl/a_buf_skew_line.sv
// a_buf_skew_line: DEPTH-stage register chain for one array row.
//   clk, rst_n  clock, async active-low reset
//   flush       synchronous clear of every stage
//   in_valid    valid entering stage 0
//   in_data     lane entering stage 0 (stored as 0 when not valid)
//   out_valid   valid leaving the last stage
//   out_data    lane leaving the last stage
module a_buf_skew_line #(
  parameter int DEPTH  = 1,
  parameter int LANE_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [LANE_W-1:0] in_data,
  output logic              out_valid,
  output logic [LANE_W-1:0] out_data
);

  logic              vld_r [DEPTH];
  logic [LANE_W-1:0] dat_r [DEPTH];

  // Shift chain; idle stages hold zero data so the array sees clean lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_r[i] <= 1'b0;
        dat_r[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_r[i] <= 1'b0;
        dat_r[i] <= '0;
      end
    end else begin
      vld_r[0] <= in_valid;
      dat_r[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_r[i] <= vld_r[i-1];
        dat_r[i] <= dat_r[i-1];
      end
    end
  end

  assign out_valid = vld_r[DEPTH-1];
  assign out_data  = dat_r[DEPTH-1];

endmodule

// File: rtl/a_buf_pp.sv
// a_buf_pp: ping-pong staging buffer for the systolic-array A operand.
// Tiles of SARRAY_H x SARRAY_H lanes are filled one column per beat and
// drained column by column, row r delayed r cycles behind row 0.
//   clk, rst_n       clock, async active-low reset
//   flush_i          synchronous clear of buffers, pointers and skew stages
//   wr_valid_i/wr_ready_o, wr_width_i, wr_data_i   column write beat
//   rd_req_valid_i/rd_req_ready_o                  drain request for oldest full tile
//   rd_data_valid_o, rd_data_o                     skewed per-row output
//   rd_width_o       width tag of the tile currently on row 0
//   full_cnt_o       number of buffers in FULL
module a_buf_pp
  import a_buf_pkg::*;
#(
  parameter int SARRAY_H = 4,
  parameter int NBUF     = 2,
  parameter int LANE_W   = 32,
  parameter int CNT_W    = $clog2(NBUF + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [TLOAD_DATAW_WIDTH-1:0] wr_width_i,
  input  logic [SARRAY_H*LANE_W-1:0]   wr_data_i,
  input  logic                         rd_req_valid_i,
  output logic                         rd_req_ready_o,
  output logic [SARRAY_H-1:0]          rd_data_valid_o,
  output logic [SARRAY_H*LANE_W-1:0]   rd_data_o,
  output logic [TLOAD_DATAW_WIDTH-1:0] rd_width_o,
  output logic [CNT_W-1:0]             full_cnt_o
);

  localparam int PTR_W = $clog2(NBUF);
  localparam int IDX_W = (SARRAY_H > 1) ? $clog2(SARRAY_H) : 1;
  localparam int DRN_W = $clog2(SARRAY_H + 1);
  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(SARRAY_H - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(SARRAY_H);

  buf_state_e         st_r      [NBUF];
  buf_state_e         st_nxt    [NBUF];
  dw_t                tag_r     [NBUF];
  dw_t                tag_nxt   [NBUF];
  logic [PTR_W-1:0]   wr_ptr_r, wr_ptr_nxt, rd_ptr_r, rd_ptr_nxt, drn_buf_r, drn_buf_nxt;
  logic [IDX_W-1:0]   wr_col_r, wr_col_nxt;
  logic [DRN_W-1:0]   drn_cnt_r, drn_cnt_nxt;
  logic [CNT_W-1:0]   full_cnt_r, full_cnt_nxt;
  logic               wr_ready_r, wr_ready_nxt, rd_ready_r, rd_ready_nxt;
  dw_t                rd_width_r, rd_width_nxt;
  logic               wr_acc_s, rd_acc_s, fill_done_s;
  logic               iss_valid_s;
  logic [PTR_W-1:0]   iss_buf_s;
  logic [IDX_W-1:0]   iss_col_s;
  logic [LANE_W-1:0]  lane_s     [SARRAY_H];
  logic [LANE_W-1:0]  row_data_s [SARRAY_H];
  logic [LANE_W-1:0]  mem_r      [NBUF][SARRAY_H][SARRAY_H];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NBUF - 1)) return '0;
    else return p + PTR_W'(1);
  endfunction

  assign wr_acc_s    = wr_valid_i && wr_ready_r && !flush_i;
  assign rd_acc_s    = rd_req_valid_i && rd_ready_r && !flush_i;
  assign fill_done_s = wr_acc_s && (wr_col_r == COL_LAST);

  // Unpack the beat: width comes from the pins on beat 0, from the stored tag afterwards.
  always_comb begin
    int unsigned bits;
    bits = (wr_col_r == '0) ? width_bits(wr_width_i) : width_bits(tag_r[wr_ptr_r]);
    for (int r = 0; r < SARRAY_H; r++) begin
      case (bits)
        32'd8:   lane_s[r] = LANE_W'(wr_data_i[r*8 +: 8]);
        32'd16:  lane_s[r] = LANE_W'(wr_data_i[r*16 +: 16]);
        default: lane_s[r] = LANE_W'(wr_data_i[r*32 +: 32]);
      endcase
    end
  end

  // Column issue: column 0 from the buffer accepted this cycle, later columns from the draining buffer.
  always_comb begin
    iss_valid_s = 1'b0;
    iss_buf_s   = drn_buf_r;
    iss_col_s   = '0;
    if (rd_acc_s) begin
      iss_valid_s = 1'b1;
      iss_buf_s   = rd_ptr_r;
    end else if ((drn_cnt_r != '0) && (drn_cnt_r != DRN_LAST)) begin
      iss_valid_s = 1'b1;
      iss_col_s   = IDX_W'(drn_cnt_r);
    end else begin
      iss_valid_s = 1'b0;
    end
    for (int r = 0; r < SARRAY_H; r++) begin
      row_data_s[r] = iss_valid_s ? mem_r[iss_buf_s][r][iss_col_s] : '0;
    end
    rd_width_nxt = (iss_valid_s && !flush_i) ? tag_r[iss_buf_s] : '0;
  end

  // Next-state of buffers, pointers and counters. drn_cnt runs 1..SARRAY_H after an
  // accept; the value SARRAY_H is the release cycle, in which a new drain may start.
  always_comb begin
    for (int b = 0; b < NBUF; b++) begin
      st_nxt[b]  = st_r[b];
      tag_nxt[b] = tag_r[b];
    end
    wr_ptr_nxt   = wr_ptr_r;
    rd_ptr_nxt   = rd_ptr_r;
    drn_buf_nxt  = drn_buf_r;
    wr_col_nxt   = wr_col_r;
    drn_cnt_nxt  = drn_cnt_r;
    full_cnt_nxt = full_cnt_r;
    if (flush_i) begin
      for (int b = 0; b < NBUF; b++) begin
        st_nxt[b]  = BUF_EMPTY;
        tag_nxt[b] = '0;
      end
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      drn_buf_nxt  = '0;
      wr_col_nxt   = '0;
      drn_cnt_nxt  = '0;
      full_cnt_nxt = '0;
    end else begin
      if (wr_acc_s) begin
        if (wr_col_r == '0) begin
          tag_nxt[wr_ptr_r] = norm_width(wr_width_i);
        end else begin
          tag_nxt[wr_ptr_r] = tag_r[wr_ptr_r];
        end
        if (wr_col_r == COL_LAST) begin
          st_nxt[wr_ptr_r] = BUF_FULL;
          wr_col_nxt       = '0;
          wr_ptr_nxt       = ptr_inc(wr_ptr_r);
        end else begin
          st_nxt[wr_ptr_r] = BUF_FILL;
          wr_col_nxt       = wr_col_r + IDX_W'(1);
        end
      end else begin
        wr_col_nxt = wr_col_r;
      end
      if (drn_cnt_r == DRN_LAST) begin
        st_nxt[drn_buf_r] = BUF_EMPTY;
        drn_cnt_nxt       = '0;
      end else if (drn_cnt_r != '0) begin
        drn_cnt_nxt = drn_cnt_r + DRN_W'(1);
      end else begin
        drn_cnt_nxt = '0;
      end
      // The accepted buffer always differs from the one being released.
      if (rd_acc_s) begin
        st_nxt[rd_ptr_r] = BUF_DRAIN;
        drn_buf_nxt      = rd_ptr_r;
        rd_ptr_nxt       = ptr_inc(rd_ptr_r);
        drn_cnt_nxt      = DRN_W'(1);
      end else begin
        drn_buf_nxt = drn_buf_r;
      end
      full_cnt_nxt = full_cnt_r + CNT_W'(fill_done_s) - CNT_W'(rd_acc_s);
    end
    wr_ready_nxt = (st_nxt[wr_ptr_nxt] == BUF_EMPTY) || (st_nxt[wr_ptr_nxt] == BUF_FILL);
    rd_ready_nxt = (st_nxt[rd_ptr_nxt] == BUF_FULL) &&
                   ((drn_cnt_nxt == '0) || (drn_cnt_nxt == DRN_LAST));
  end

  // Control state and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBUF; b++) begin
        st_r[b]  <= BUF_EMPTY;
        tag_r[b] <= '0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      drn_buf_r  <= '0;
      wr_col_r   <= '0;
      drn_cnt_r  <= '0;
      full_cnt_r <= '0;
      wr_ready_r <= 1'b0;
      rd_ready_r <= 1'b0;
      rd_width_r <= '0;
    end else begin
      for (int b = 0; b < NBUF; b++) begin
        st_r[b]  <= st_nxt[b];
        tag_r[b] <= tag_nxt[b];
      end
      wr_ptr_r   <= wr_ptr_nxt;
      rd_ptr_r   <= rd_ptr_nxt;
      drn_buf_r  <= drn_buf_nxt;
      wr_col_r   <= wr_col_nxt;
      drn_cnt_r  <= drn_cnt_nxt;
      full_cnt_r <= full_cnt_nxt;
      wr_ready_r <= wr_ready_nxt;
      rd_ready_r <= rd_ready_nxt;
      rd_width_r <= rd_width_nxt;
    end
  end

  // Lane storage, written one column per accepted beat; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      for (int r = 0; r < SARRAY_H; r++) begin
        mem_r[wr_ptr_r][r][wr_col_r] <= lane_s[r];
      end
    end
  end

  for (genvar r = 0; r < SARRAY_H; r++) begin : g_row
    a_buf_skew_line #(
      .DEPTH  (r + 1),
      .LANE_W (LANE_W)
    ) u_skew (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush_i),
      .in_valid  (iss_valid_s),
      .in_data   (row_data_s[r]),
      .out_valid (rd_data_valid_o[r]),
      .out_data  (rd_data_o[r*LANE_W +: LANE_W])
    );
  end

  a_buf_pp_chk u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid_i),
    .wr_ready (wr_ready_r),
    .wr_width (wr_width_i)
  );

  assign wr_ready_o     = wr_ready_r;
  assign rd_req_ready_o = rd_ready_r;
  assign rd_width_o     = rd_width_r;
  assign full_cnt_o     = full_cnt_r;

endmodule

// File: tb/tb_a_buf_pp.sv
// tb_a_buf_pp: randomized and directed stimulus for a_buf_pp, checked every
// cycle against a tile-queue reference model.
module tb_a_buf_pp;
  import a_buf_pkg::*;

  localparam int H    = 4;
  localparam int NB   = 2;
  localparam int LW   = 32;
  localparam int CW   = $clog2(NB + 1);
  localparam int RING = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush_i;
  logic            wr_valid_i;
  logic            wr_ready_o;
  logic [2:0]      wr_width_i;
  logic [H*LW-1:0] wr_data_i;
  logic            rd_req_valid_i;
  logic            rd_req_ready_o;
  logic [H-1:0]    rd_data_valid_o;
  logic [H*LW-1:0] rd_data_o;
  logic [2:0]      rd_width_o;
  logic [CW-1:0]   full_cnt_o;

  a_buf_pp #(.SARRAY_H(H), .NBUF(NB), .LANE_W(LW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .wr_valid_i      (wr_valid_i),
    .wr_ready_o      (wr_ready_o),
    .wr_width_i      (wr_width_i),
    .wr_data_i       (wr_data_i),
    .rd_req_valid_i  (rd_req_valid_i),
    .rd_req_ready_o  (rd_req_ready_o),
    .rd_data_valid_o (rd_data_valid_o),
    .rd_data_o       (rd_data_o),
    .rd_width_o      (rd_width_o),
    .full_cnt_o      (full_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [H*LW-1:0] got, input logic [H*LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: tiles as flat arrays, a FIFO of full tiles, release times of drains.
  typedef struct packed {
    logic [2:0]        tag;
    logic [H*H*LW-1:0] d;   // element (row r, col k) at ((r*H)+k)*LW
  } tile_s;

  tile_s       full_q[$];
  tile_s       cur;
  int          cur_col  = 0;
  int          drain_rel[$];
  int          last_acc = -100;
  int          cyc      = 0;
  logic        exp_v [RING][H];
  logic [LW-1:0] exp_d [RING][H];
  logic [2:0]  exp_w [RING];

  task automatic clear_ring();
    for (int s = 0; s < RING; s++) begin
      exp_w[s] = 3'b000;
      for (int r = 0; r < H; r++) begin
        exp_v[s][r] = 1'b0;
        exp_d[s][r] = '0;
      end
    end
  endtask

  function automatic logic [H*LW-1:0] rand_data();
    logic [H*LW-1:0] v;
    for (int i = 0; i < H; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input logic wv, input logic [H*LW-1:0] wd, input logic [2:0] ww,
                      input logic rv, input logic fl);
    logic e_wr, e_rd;
    logic [H-1:0] ev;
    int s, w;
    tile_s t;
    logic [H*LW-1:0] tmp;
    longint unsigned m;
    while (drain_rel.size() > 0 && drain_rel[0] <= cyc) void'(drain_rel.pop_front());
    e_wr = (cur_col > 0) || ((full_q.size() + drain_rel.size()) < NB);
    e_rd = (full_q.size() > 0) && ((cyc - last_acc) >= H);
    s = cyc % RING;
    check_val("wr_ready", wr_ready_o, e_wr);
    check_val("rd_req_ready", rd_req_ready_o, e_rd);
    check_val("full_cnt", full_cnt_o, full_q.size());
    for (int r = 0; r < H; r++) ev[r] = exp_v[s][r];
    check_val("rd_valid", rd_data_valid_o, ev);
    for (int r = 0; r < H; r++)
      check_val($sformatf("row%0d_data", r), rd_data_o[r*LW +: LW], exp_v[s][r] ? exp_d[s][r] : '0);
    check_val("rd_width", rd_width_o, exp_w[s]);
    exp_w[s] = 3'b000;
    for (int r = 0; r < H; r++) begin
      exp_v[s][r] = 1'b0;
      exp_d[s][r] = '0;
    end

    wr_valid_i = wv; wr_data_i = wd; wr_width_i = ww;
    rd_req_valid_i = rv; flush_i = fl;

    if (fl) begin
      full_q.delete();
      drain_rel.delete();
      cur_col  = 0;
      last_acc = -100;
      clear_ring();
    end else begin
      if (rv && e_rd) begin
        t = full_q.pop_front();
        last_acc = cyc;
        drain_rel.push_back(cyc + H + 1);
        for (int k = 0; k < H; k++) begin
          exp_w[(cyc + 1 + k) % RING] = t.tag;
          for (int r = 0; r < H; r++) begin
            exp_v[(cyc + 1 + k + r) % RING][r] = 1'b1;
            exp_d[(cyc + 1 + k + r) % RING][r] = t.d[((r*H)+k)*LW +: LW];
          end
        end
      end
      if (wv && e_wr) begin
        if (cur_col == 0) cur.tag = ww;
        w = (cur.tag == 3'b001) ? 8 : (cur.tag == 3'b010) ? 16 : 32;
        m = (64'd1 << w) - 64'd1;
        for (int r = 0; r < H; r++) begin
          tmp = wd >> (r * w);
          cur.d[((r*H)+cur_col)*LW +: LW] = tmp[31:0] & m[31:0];
        end
        cur_col++;
        if (cur_col == H) begin
          full_q.push_back(cur);
          cur_col = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 3'b100, 1'b0, 1'b0);
  endtask

  // Fill one tile (if none is full) and get a drain request accepted.
  task automatic fill_and_accept();
    int guard = 0;
    int acc0;
    while (full_q.size() == 0 && guard < 20) begin
      step(1'b1, rand_data(), 3'b100, 1'b0, 1'b0);
      guard++;
    end
    acc0 = last_acc;
    while (last_acc == acc0 && guard < 40) begin
      step(1'b0, '0, 3'b100, 1'b1, 1'b0);
      guard++;
    end
    check_val("accept_timeout", (last_acc != acc0), 1'b1);
  endtask

  initial begin
    logic [H*LW-1:0] d;
    clear_ring();
    rst_n = 1'b0; flush_i = 1'b0; wr_valid_i = 1'b0; wr_width_i = 3'b100;
    wr_data_i = '0; rd_req_valid_i = 1'b0;
    #12;
    check_val("rst_wr_ready", wr_ready_o, 1'b0);
    check_val("rst_rd_ready", rd_req_ready_o, 1'b0);
    check_val("rst_valid", rd_data_valid_o, '0);
    check_val("rst_data", rd_data_o, '0);
    check_val("rst_full_cnt", full_cnt_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4BYTE tile with element (r,k) = 0x100*k + r, then drain.
    for (int k = 0; k < H; k++) begin
      for (int r = 0; r < H; r++) d[r*32 +: 32] = 32'h100 * k + r;
      step(1'b1, d, 3'b100, 1'b0, 1'b0);
    end
    step(1'b0, '0, 3'b100, 1'b1, 1'b0);
    idle(2 * H);

    // 1BYTE tile: low word 0x44332211 on every beat, upper bits random.
    for (int k = 0; k < H; k++) begin
      d = rand_data();
      d[31:0] = 32'h4433_2211;
      step(1'b1, d, 3'b001, 1'b0, 1'b0);
    end
    step(1'b0, '0, 3'b100, 1'b1, 1'b0);
    idle(2 * H);

    // Width change mid-fill: beat 0 is 2BYTE, later beats claim 4BYTE.
    step(1'b1, rand_data(), 3'b010, 1'b0, 1'b0);
    for (int k = 1; k < H; k++) step(1'b1, rand_data(), 3'b100, 1'b0, 1'b0);
    step(1'b0, '0, 3'b100, 1'b1, 1'b0);
    idle(2 * H);

    // Read request with nothing full, then a fill completes while it is held.
    idle(1);
    for (int k = 0; k < H; k++) step(1'b1, rand_data(), 3'b100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 3'b100, 1'b1, 1'b0);
    idle(2 * H);

    // Ping-pong: fill both buffers plus one refused beat, then stream.
    step(1'b0, '0, 3'b100, 1'b0, 1'b1);
    for (int i = 0; i < 2 * H + 1; i++) step(1'b1, rand_data(), 3'b100, 1'b0, 1'b0);
    for (int i = 0; i < 3 * H; i++) step(1'b1, rand_data(), 3'b001 << $urandom_range(0, 2), 1'b1, 1'b0);
    idle(2 * H);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) != 0), rand_data(), 3'b001 << $urandom_range(0, 2),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) == 0));
    end
    idle(2 * H);

    // Flush two cycles into a drain.
    fill_and_accept();
    idle(1);
    step(1'b0, '0, 3'b100, 1'b0, 1'b1);
    idle(H + 2);

    // Asynchronous reset two cycles into a drain.
    fill_and_accept();
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", rd_data_valid_o, '0);
    check_val("arst_data", rd_data_o, '0);
    check_val("arst_width", rd_width_o, '0);
    check_val("arst_full_cnt", full_cnt_o, '0);
    check_val("arst_wr_ready", wr_ready_o, 1'b0);
    check_val("arst_rd_ready", rd_req_ready_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/a_buf_pp.md
Name: a_buf_pp

Overview:
- Parametrised ping-pong staging buffer for the systolic array A operand, between the tile-load path and the array's left edge.
- Fills NBUF tile buffers of SARRAY_H x SARRAY_H 32-bit lanes, one column per beat, with per-element width modes.
- Drains full tiles column by column with a diagonal row skew, so row i enters the array i cycles after row 0.
- Buffers are allocated and retired round-robin; fill and drain overlap for continuous streaming.

Parameters:
- SARRAY_H, 4, rows and columns of the array and of each tile.
- NBUF, 2, number of tile buffers; must be 2 or more.
- LANE_W, 32, stored lane width in bits.
- CNT_W, $clog2(NBUF+1), width of the full-buffer count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all buffers and pointers.
- wr_valid_i  in  1  write beat valid.
- wr_ready_o  out  1  write beat accepted when high with wr_valid_i.
- wr_width_i  in  TLOAD_DATAW_WIDTH  one-hot element width (BYTE/2BYTE/4BYTE idx).
- wr_data_i  in  SARRAY_H*LANE_W  one column; element r is packed at r*w for w = 8/16/32.
- rd_req_valid_i  in  1  request to drain the oldest full tile.
- rd_req_ready_o  out  1  request accepted.
- rd_data_valid_o  out  SARRAY_H  per-row output valid.
- rd_data_o  out  SARRAY_H*LANE_W  row r on bits [r*LANE_W +: LANE_W].
- rd_width_o  out  TLOAD_DATAW_WIDTH  width tag of the tile currently on row 0.
- full_cnt_o  out  CNT_W  number of buffers in FULL.

Behaviour:
- Reset: all buffers EMPTY; wr_ptr = rd_ptr = 0; all counters 0; every output 0, except wr_ready_o = 1 once out of reset. Lane storage is not reset.
- Per-buffer states: EMPTY -> FILL (first accepted beat) -> FULL (SARRAY_H-th beat) -> DRAIN (read accepted) -> EMPTY (cycle after last column issued).
- EMPTY -> FULL directly when SARRAY_H = 1.
- Write:
  - wr_ready_o = buffer[wr_ptr] is EMPTY or FILL.
  - Beat k writes column k; element r is zero-extended into lane [r][k].
  - The width is latched on beat 0 and stored as the tile tag; width changes on later beats are ignored.
  - On beat SARRAY_H-1 the buffer goes FULL and wr_ptr advances mod NBUF.
  - A non-one-hot width is treated as 4BYTE (flagged by a simulation assertion).
- Read:
  - rd_req_ready_o = buffer[rd_ptr] is FULL, and the drain counter is idle or on its last column.
  - If a request is accepted in cycle T, column k is issued at T+k for k = 0..SARRAY_H-1.
  - rd_ptr advances at acceptance; the buffer returns to EMPTY at T+SARRAY_H.
- Skew and latency: row r of column k appears on rd_data_o at cycle T+1+k+r, with rd_data_valid_o[r] high over T+1+r .. T+SARRAY_H+r.
  - Row 0 is one register stage; row r has r+1 stages.
  - When no data is present, rd_data_o lanes are 0.
- Back-to-back requests accepted at T and T+SARRAY_H give gap-free valid on every row.
- Simultaneous events:
  - Write into buffer A and drain of buffer B in the same cycle are independent.
  - Releasing a buffer to EMPTY and a write accepted into the same buffer cannot coincide: wr_ready_o uses the registered state, so the write is accepted one cycle later.
  - full_cnt_o updates on a same-cycle fill-complete and drain-accept with net 0.
- Full/empty:
  - All NBUF buffers FULL or DRAIN -> wr_ready_o = 0.
  - No buffer FULL -> rd_req_ready_o = 0, and the request is held by the producer.
- flush_i: state returns to reset values the next cycle, including in-flight skew stages (valids cleared). flush_i has priority over same-cycle wr/rd handshakes, which are dropped.
- Reset mid-drain: outputs drop to 0 asynchronously.

Decomposition:
- a_buf_pkg:
  - TLOAD_DATAW_WIDTH and the TLOAD_DW_BYTE/2BYTE/4BYTE_IDX constants.
  - Buffer state encoding (EMPTY/FILL/FULL/DRAIN).
  - Width-to-bits function for unpacking.
- Sub-module a_buf_skew_line: parametrised DEPTH register chain carrying valid and LANE_W data, with flush. Instantiated once per row with DEPTH = r+1.

Test Plan (SARRAY_H=4, NBUF=2):
- 4BYTE fill: beats with element [r][k] = 0x100*k+r, then a read accepted at T -> row 2 shows 0x002,0x102,0x202,0x302 at T+3..T+6, and valid[2] is high exactly for those cycles.
- 1BYTE fill: wr_data low 32 bits = 0x44332211 each beat -> every lane is zero-extended, row r = 0x11/0x22/0x33/0x44 for r = 0..3; rd_width_o = BYTE.
- Ping-pong streaming: fill both buffers, wr_ready_o = 0 after the 8th beat, full_cnt_o = 2. Then reads at T and T+4 -> valid[0] continuous from T+1 to T+8, and wr_ready_o rises at T+5.
- Read with nothing full: rd_req_valid_i = 1 with full_cnt_o = 0 -> rd_req_ready_o = 0 and no valids. Completing a fill then gives acceptance the next cycle.
- Width change mid-fill: beat 0 = 2BYTE, beats 1-3 = 4BYTE -> all columns are unpacked as 2BYTE and the tag is 2BYTE.
- Flush at T+2 of a drain: all valids are 0 from T+3, full_cnt_o = 0, wr_ready_o = 1. Repeat with rst_n low mid-drain -> outputs 0 immediately.
